// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: two-requester write arbiter and read front end for an
// external instruction register of 2**PTR_W entries.
//
// Ports:
//   clk, reset_n       single clock; synchronous active-low reset
//   clr                synchronous soft clear of pointers, count and valid map
//   req / gnt          per-requester write request / one-hot combinational grant
//   req_a/req_b/req_opc  per-requester operands and opcode
//   load_en, write_pointer, operand_a, operand_b, opcode
//                      registered write port towards the instruction register
//   rd_req, rd_ptr     read request
//   read_pointer, instruction_word  read port of the instruction register
//   rd_valid, rd_data, rd_err       one-cycle read response
//   full, count        occupancy status
//
// Entry layout of instruction_word / rd_data: {opcode, operand_a, operand_b}.
//
// Build option: define INSTR_REG_CTRL_WRAP_EN to let writes wrap and overwrite
// the oldest entry instead of stopping in FULL.

module instr_reg_ctrl #(
  parameter int unsigned PTR_W  = 5,
  parameter int unsigned OPND_W = 32,
  parameter int unsigned OPC_W  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clr,
  input  logic [1:0]                     req,
  output logic [1:0]                     gnt,
  input  logic [1:0][OPND_W-1:0]         req_a,
  input  logic [1:0][OPND_W-1:0]         req_b,
  input  logic [1:0][OPC_W-1:0]          req_opc,
  output logic                           load_en,
  output logic [PTR_W-1:0]               write_pointer,
  output logic [OPND_W-1:0]              operand_a,
  output logic [OPND_W-1:0]              operand_b,
  output logic [OPC_W-1:0]               opcode,
  input  logic                           rd_req,
  input  logic [PTR_W-1:0]               rd_ptr,
  output logic [PTR_W-1:0]               read_pointer,
  input  logic [OPC_W+2*OPND_W-1:0]      instruction_word,
  output logic                           rd_valid,
  output logic [OPC_W+2*OPND_W-1:0]      rd_data,
  output logic                           rd_err,
  output logic                           full,
  output logic [PTR_W:0]                 count
);

  localparam int unsigned DEPTH = 2**PTR_W;
  localparam logic [PTR_W:0] DEPTH_CNT = {1'b1, {PTR_W{1'b0}}};

`ifdef INSTR_REG_CTRL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W:0]      r_count;
  logic [DEPTH-1:0]    r_valid;
  logic                r_last;     // last winner; the other side wins a tie
  logic                r_load_en;
  logic [PTR_W-1:0]    r_wp;
  logic [OPND_W-1:0]   r_opa, r_opb;
  logic [OPC_W-1:0]    r_opc;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic                r_rd_valid;
  logic                r_rd_err;
  logic [1:0]          w_gnt;
  logic                w_accept;
  logic                w_win;

  // Arbitration and next state
  always_comb begin
    w_gnt = 2'b00;
    if (reset_n && !clr && r_state != FULL) begin
      unique case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
    w_win    = w_gnt[1];
    w_accept = |(req & w_gnt);

    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, LOAD: begin
          if (!w_accept)
            w_state_nxt = IDLE;
          else if (!WRAP_EN && r_count == DEPTH_CNT - 1'b1)
            w_state_nxt = FULL;
          else
            w_state_nxt = LOAD;
        end
        FULL:    w_state_nxt = FULL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_last     <= 1'b1;
      r_load_en  <= 1'b0;
      r_wp       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_opc      <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_load_en <= w_accept;
      if (w_accept) begin
        r_wp   <= r_wr_ptr;
        r_opa  <= req_a[w_win];
        r_opb  <= req_b[w_win];
        r_opc  <= req_opc[w_win];
        r_last <= w_win;
      end
      if (clr) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_valid  <= '0;
      end else begin
        // Valid bit lands at the end of the load_en cycle, so a read
        // registered at the same edge still sees the pre-write bit.
        if (r_load_en)
          r_valid[r_wp] <= 1'b1;
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_count != DEPTH_CNT)
            r_count <= r_count + 1'b1;
        end
      end
      // Read path is independent of the write FSM and of clr.
      r_rd_valid <= rd_req;
      r_rd_err   <= rd_req & ~r_valid[rd_ptr];
      if (rd_req)
        r_rd_ptr <= rd_ptr;
    end
  end

  assign gnt           = w_gnt;
  assign load_en       = r_load_en;
  assign write_pointer = r_wp;
  assign operand_a     = r_opa;
  assign operand_b     = r_opb;
  assign opcode        = r_opc;
  assign read_pointer  = r_rd_ptr;
  assign rd_valid      = r_rd_valid;
  assign rd_err        = r_rd_err;
  assign rd_data       = r_rd_valid ? instruction_word : '0;
  assign full          = (r_state == FULL);
  assign count         = r_count;

endmodule

// File: doc/instr_reg_ctrl.md
INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

Interface
REQ-001 SHALL have parameter PTR_W, default 5, pointer width; depth = 2**PTR_W entries.
REQ-002 SHALL have parameter OPND_W, default 32, operand width.
REQ-003 SHALL have parameter OPC_W, default 4, opcode width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk (in, 1), the single clock, all state updated on its rising edge.
REQ-005 SHALL have reset_n (in, 1), synchronous active-low reset, sampled on rising clk.
REQ-006 SHALL have clr (in, 1): synchronous soft clear of pointers, count and valid map.
REQ-007 SHALL have req (in, 2): per-requester write request.
REQ-008 SHALL have gnt (out, 2): one-hot grant, combinational, same cycle as req.
REQ-009 SHALL have req_a[n] / req_b[n] / req_opc[n] (in, 2 x OPND_W, 2 x OPND_W, 2 x OPC_W): per-requester operands and opcode.
REQ-010 SHALL have load_en (out, 1), write_pointer (out, PTR_W), operand_a / operand_b (out, OPND_W), opcode (out, OPC_W): instruction-register write port.
REQ-011 SHALL have rd_req (in, 1), rd_ptr (in, PTR_W): read request.
REQ-012 SHALL have read_pointer (out, PTR_W), instruction_word (in, register entry width): instruction-register read port.
REQ-013 SHALL have rd_valid (out, 1), rd_data (out, entry width), rd_err (out, 1): read response.
REQ-014 SHALL have full (out, 1), count (out, PTR_W+1): occupancy status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, FULL.
REQ-016 Accept = req[n] & gnt[n]; grant only when state != FULL and clr = 0; at most one gnt bit high.
REQ-017 Arbitration: round-robin; a last-winner flag gives the other requester priority on contention; a sole requester always wins.
REQ-018 On accept at edge N: load_en = 1, operands/opcode = winner's inputs, write_pointer = wr_ptr in cycle N+1; otherwise load_en = 0 and operand outputs hold.
REQ-019 wr_ptr increments by 1 per accept, modulo 2**PTR_W.
REQ-020 count increments per accept, saturating at 2**PTR_W; full = (state == FULL).
REQ-021 Transitions: IDLE->LOAD on accept; LOAD->LOAD on accept; LOAD->IDLE on no accept; ->FULL when an accept makes count = 2**PTR_W (per REQ-030); FULL->IDLE only on clr or reset.
REQ-022 Maintain a valid bit per entry, set at the edge that ends a load_en cycle for write_pointer.
REQ-023 Read: rd_req at edge N registers read_pointer = rd_ptr; rd_valid = 1 for exactly cycle N+1; rd_data = instruction_word during that cycle.
REQ-024 rd_err, registered at edge N, = 1 if valid[rd_ptr] was 0 in cycle N; rd_err = 0 whenever rd_valid = 0.
REQ-025 A read and a pending write to the same entry SHALL return pre-write contents, with rd_err derived from the pre-write valid bit.
REQ-026 Reads are independent of the write FSM and SHALL be served in every state, including FULL.
REQ-027 clr = 1: wr_ptr = 0, count = 0, valid map = 0, state = IDLE, gnt = 0, load_en = 0 next cycle; an in-flight load_en cycle still completes; reads are unaffected.

Reset
REQ-028 With reset_n = 0 at a rising edge: state = IDLE, wr_ptr = 0, count = 0, valid map = 0, last-winner = requester 1 (so requester 0 wins first), load_en = 0, write_pointer = 0, operand_a = 0, operand_b = 0, opcode = 0, read_pointer = 0, rd_valid = 0, rd_err = 0, full = 0; gnt = 0 while reset_n = 0.
REQ-029 Reset mid-operation SHALL discard any accepted but not yet issued load and any pending read response.

Configuration
REQ-030 Macro INSTR_REG_CTRL_WRAP_EN defined: FULL is never entered; writes continue past 2**PTR_W entries and overwrite the oldest entry; count saturates; full = 0. Undefined: FULL is entered after 2**PTR_W accepts and blocks all grants until clr or reset.

Verification
REQ-031 Reset, then req = 2'b01 for 3 cycles -> gnt = 01 each cycle; load_en pulses with write_pointer 0, 1, 2; count = 3.
REQ-032 req = 2'b11 held for 4 cycles -> gnt = 01, 10, 01, 10 (alternating).
REQ-033 Macro undefined: 32 accepts -> full = 1; 33rd req gets gnt = 0; clr -> full = 0, next accept writes pointer 0.
REQ-034 Macro defined: 33 accepts -> full = 0; 33rd load writes pointer 0; count = 32.
REQ-035 Write entry 5 with operand_a = 7, then rd_req with rd_ptr = 5 -> rd_valid one cycle later, rd_data = entry contents, rd_err = 0; rd_ptr = 9 (unwritten) -> rd_err = 1.
REQ-036 reset_n = 0 in the cycle after an accept -> no load_en, all outputs at reset values next cycle.
